quad_dec_sysid_checker: RTL

//   Avalon-MM read master sitting directly upstream of the Quad_Dec system-ID slave.
//   On a start pulse it reads the ID word (address 0) and then the timestamp word (address 1).
//   It compares both against build-time expected values and retries on mismatch.
//   It reports pass / mismatch / timeout so boot logic can gate the quadrature decoder.

---
 rtl/quad_dec_sysid_checker.sv | 129 ++++++++++++
 1 files changed

// File: rtl/quad_dec_sysid_checker.sv
// quad_dec_sysid_checker: reads and verifies the Quad_Dec system-ID words over Avalon-MM before boot
module quad_dec_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1526566770,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          RETRY_LIMIT    = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        mismatch,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [3:0]  attempts
);
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
    localparam logic [3:0]  RT_LIM = 4'(RETRY_LIMIT);
    typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CHECK, DONE} state_t;
    state_t      state_q, state_d;
    logic        addr_q, addr_d;
    logic        pass_q, pass_d, mis_q, mis_d, to_q, to_d;
    logic [15:0] wait_q, wait_d;
    logic [31:0] id_q, id_d, ts_q, ts_d;
    logic [3:0]  att_q, att_d;
    logic        accept, stall;
    // read strobe is decoded from state so reset removes it without waiting for a clock
    assign avm_read    = (state_q == RD_ID) || (state_q == RD_TS);
    assign accept      = avm_read & ~avm_waitrequest;
    assign stall       = avm_read & avm_waitrequest;
    assign avm_address = addr_q;
    assign busy        = (state_q == RD_ID) || (state_q == RD_TS) || (state_q == CHECK);
    assign done        = state_q == DONE;
    assign pass        = pass_q;
    assign mismatch    = mis_q;
    assign timeout     = to_q;
    assign id_value    = id_q;
    assign ts_value    = ts_q;
    assign attempts    = att_q;
    // next-state: read sequencing, stall timeout, compare and retry decision
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pass_d  = pass_q;
        mis_d   = mis_q;
        to_d    = to_q;
        wait_d  = wait_q;
        id_d    = id_q;
        ts_d    = ts_q;
        att_d   = att_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RD_ID;
                    addr_d  = 1'b0;
                    pass_d  = 1'b0;
                    mis_d   = 1'b0;
                    to_d    = 1'b0;
                    wait_d  = '0;
                    att_d   = '0;
                end
            end
            RD_ID, RD_TS: begin
                if (accept) begin
                    wait_d = '0;
                    if (state_q == RD_ID) begin
                        id_d    = avm_readdata;
                        addr_d  = 1'b1;
                        state_d = RD_TS;
                    end else begin
                        ts_d    = avm_readdata;
                        state_d = CHECK;
                    end
                end else if (stall) begin
                    wait_d = wait_q + 16'd1;
                    if (wait_d == TO_LIM) begin
                        to_d    = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            CHECK: begin
                addr_d = 1'b0;
                if (id_q == EXPECTED_ID && ts_q == EXPECTED_TS) begin
                    pass_d  = 1'b1;
                    state_d = DONE;
                end else if (att_q < RT_LIM) begin
                    att_d   = att_q + 4'd1;
                    state_d = RD_ID;
                end else begin
                    mis_d   = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // state and status registers, cleared asynchronously
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= 1'b0;
            pass_q  <= 1'b0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
            wait_q  <= '0;
            id_q    <= '0;
            ts_q    <= '0;
            att_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pass_q  <= pass_d;
            mis_q   <= mis_d;
            to_q    <= to_d;
            wait_q  <= wait_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
            att_q   <= att_d;
        end
    end
endmodule
